// File: rtl/cmd_frame_pkg.sv
// Shared constants, opcode classes and FSM states for the command frame parser.
package cmd_frame_pkg;

  localparam logic [7:0] HDR0 = 8'hEB;
  localparam logic [7:0] HDR1 = 8'h90;
  localparam logic [7:0] TRL0 = 8'h09;
  localparam logic [7:0] TRL1 = 8'hD7;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NACK = 8'h15;

  localparam logic [3:0] CLS_SEL     = 4'h1;
  localparam logic [3:0] CLS_RST     = 4'h2;
  localparam logic [3:0] CLS_RST_ALL = 4'h3;
  localparam logic [3:0] CLS_PWR_ON  = 4'h4;
  localparam logic [3:0] CLS_PWR_OFF = 4'h5;

  localparam int unsigned RESP_LEN = 6;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_EXEC,
    ST_RESP
  } state_e;

endpackage

// File: rtl/reset_pulse_gen.sv
// Retriggerable fixed-length reset pulse for one CPU channel.
module reset_pulse_gen #(
  parameter int unsigned RESET_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int unsigned CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  // A trigger (re)loads the counter; the pulse drops once it has run out.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
      cnt_q <= '0;
    end else if (trig) begin
      pulse <= 1'b1;
      cnt_q <= CW'(RESET_CYCLES - 1);
    end else if (pulse) begin
      if (cnt_q == '0) pulse <= 1'b0;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Gap-delimited command frame parser: validates frames from the RX FIFO,
// executes host-select / reset / power opcodes and answers with ACK/NACK.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN    = 8,
  parameter int unsigned NUM_CPU      = 2,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned CNT_W        = 5,
  parameter int unsigned IDLE_GAP     = 320,
  parameter int unsigned RESET_CYCLES = 1000000,
  parameter logic [7:0]  DEV_ADDR     = 8'hAB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   rf_counter,
  input  logic [7:0]         rdr,
  output logic               rf_pop,
  input  logic               tf_full,
  output logic [7:0]         tdr,
  output logic               tf_push,
  input  logic [SEL_W-1:0]   cur_host,
  output logic [SEL_W-1:0]   host_sel,
  output logic               force_swi,
  output logic [NUM_CPU-1:0] cpu_reset,
  output logic [NUM_CPU-1:0] power_on,
  output logic               frame_ok,
  output logic               error
);

  localparam int unsigned BC_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);

  state_e             state_q, state_d;
  logic [7:0]         byte_q [FRAME_LEN];
  logic [BC_W-1:0]    count_q;
  logic               overlong_q;
  logic [GAP_W-1:0]   gap_q;
  logic [7:0]         resp_code_q, resp_code_d;
  logic [7:0]         resp_seq_q, resp_seq_d;
  logic [2:0]         resp_idx_q, resp_idx_d;

  logic               gap_full_c, can_pop_c, pop_c;
  logic [7:0]         sum_c, resp_byte_c;
  logic               frame_valid_c, ch_ok_c, is_host_c;
  logic [3:0]         cls_c, ch_c;
  logic [NUM_CPU-1:0] chan_mask_c, rst_trig_c;

  logic               rf_pop_d, tf_push_d, force_swi_d, frame_ok_d, error_d;
  logic [7:0]         tdr_d;
  logic [SEL_W-1:0]   host_sel_d;
  logic [NUM_CPU-1:0] power_on_d;

  assign gap_full_c = (gap_q == GAP_W'(IDLE_GAP));
  assign can_pop_c  = (rf_counter != '0) && !rf_pop;
  assign cls_c      = byte_q[4][7:4];
  assign ch_c       = byte_q[4][3:0];

  // Frame validation: length, header, trailer, address and payload checksum.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 2; i <= FRAME_LEN - 3; i++) sum_c = sum_c + byte_q[i];
    frame_valid_c = (count_q == BC_W'(FRAME_LEN)) && !overlong_q &&
                    (byte_q[0] == HDR0) && (byte_q[1] == HDR1) &&
                    (byte_q[FRAME_LEN-2] == TRL0) && (byte_q[FRAME_LEN-1] == TRL1) &&
                    (byte_q[3] == DEV_ADDR) && (sum_c == 8'h00);
  end

  // Channel decode of the opcode low nibble.
  always_comb begin
    ch_ok_c   = 32'(ch_c) < NUM_CPU;
    is_host_c = 32'(ch_c) == 32'(cur_host);
    for (int unsigned c = 0; c < NUM_CPU; c++) chan_mask_c[c] = (32'(ch_c) == c);
  end

  // Response byte selected by the emit index.
  always_comb begin
    case (resp_idx_q)
      3'd0:    resp_byte_c = HDR0;
      3'd1:    resp_byte_c = HDR1;
      3'd2:    resp_byte_c = resp_seq_q;
      3'd3:    resp_byte_c = resp_code_q;
      3'd4:    resp_byte_c = TRL0;
      default: resp_byte_c = TRL1;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pop_c       = 1'b0;
    rf_pop_d    = 1'b0;
    tf_push_d   = 1'b0;
    tdr_d       = tdr;
    host_sel_d  = host_sel;
    force_swi_d = 1'b0;
    power_on_d  = power_on;
    frame_ok_d  = 1'b0;
    error_d     = 1'b0;
    rst_trig_c  = '0;
    resp_code_d = resp_code_q;
    resp_seq_d  = resp_seq_q;
    resp_idx_d  = resp_idx_q;

    case (state_q)
      ST_SYNC: begin
        if (gap_full_c) state_d = ST_IDLE;
        else            pop_c   = can_pop_c;
      end
      ST_IDLE: begin
        if (can_pop_c) begin
          pop_c   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (gap_full_c) state_d = ST_CHECK;
        else            pop_c   = can_pop_c;
      end
      ST_CHECK: begin
        resp_seq_d = (count_q >= BC_W'(3)) ? byte_q[2] : 8'h00;
        resp_idx_d = '0;
        if (frame_valid_c) begin
          state_d = ST_EXEC;
        end else begin
          error_d     = 1'b1;
          resp_code_d = NACK;
          state_d     = ST_RESP;
        end
      end
      ST_EXEC: begin
        case (cls_c)
          CLS_SEL: if (ch_ok_c) begin
            host_sel_d  = SEL_W'(ch_c);
            force_swi_d = 1'b1;
            frame_ok_d  = 1'b1;
          end
          CLS_RST: if (ch_ok_c && !is_host_c) begin
            rst_trig_c = chan_mask_c;
            frame_ok_d = 1'b1;
          end
          CLS_RST_ALL: begin
            rst_trig_c  = '1;
            host_sel_d  = ch_ok_c ? SEL_W'(ch_c) : '0;
            force_swi_d = 1'b1;
            frame_ok_d  = 1'b1;
          end
          CLS_PWR_ON: if (ch_ok_c) begin
            power_on_d = power_on | chan_mask_c;
            frame_ok_d = 1'b1;
          end
          CLS_PWR_OFF: if (ch_ok_c && !is_host_c) begin
            power_on_d = power_on & ~chan_mask_c;
            frame_ok_d = 1'b1;
          end
          default: ;
        endcase
        error_d     = !frame_ok_d;
        resp_code_d = frame_ok_d ? ACK : NACK;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (!tf_full) begin
          tdr_d      = resp_byte_c;
          tf_push_d  = 1'b1;
          resp_idx_d = resp_idx_q + 3'd1;
          if (resp_idx_q == 3'(RESP_LEN - 1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SYNC;
    endcase
    rf_pop_d = pop_c;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      rf_pop      <= 1'b0;
      tf_push     <= 1'b0;
      tdr         <= '0;
      host_sel    <= '0;
      force_swi   <= 1'b0;
      power_on    <= '1;
      frame_ok    <= 1'b0;
      error       <= 1'b0;
      resp_code_q <= '0;
      resp_seq_q  <= '0;
      resp_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_pop      <= rf_pop_d;
      tf_push     <= tf_push_d;
      tdr         <= tdr_d;
      host_sel    <= host_sel_d;
      force_swi   <= force_swi_d;
      power_on    <= power_on_d;
      frame_ok    <= frame_ok_d;
      error       <= error_d;
      resp_code_q <= resp_code_d;
      resp_seq_q  <= resp_seq_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

  // Idle-gap counter and frame capture buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q      <= '0;
      count_q    <= '0;
      overlong_q <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) byte_q[i] <= '0;
    end else begin
      if (pop_c)                              gap_q <= '0;
      else if (rf_counter == '0 && !gap_full_c) gap_q <= gap_q + 1'b1;

      if (pop_c && state_q == ST_IDLE) begin
        byte_q[0]  <= rdr;
        count_q    <= BC_W'(1);
        overlong_q <= 1'b0;
      end else if (pop_c && state_q == ST_COLLECT) begin
        if (count_q < BC_W'(FRAME_LEN)) begin
          for (int i = 0; i < FRAME_LEN; i++)
            if (count_q == BC_W'(i)) byte_q[i] <= rdr;
          count_q <= count_q + 1'b1;
        end else begin
          overlong_q <= 1'b1;
        end
      end
    end
  end

  // One retriggerable reset pulse engine per CPU channel.
  for (genvar c = 0; c < NUM_CPU; c++) begin : g_rst
    reset_pulse_gen #(.RESET_CYCLES(RESET_CYCLES)) u_rst (
      .clk   (clk),
      .rst   (rst),
      .trig  (rst_trig_c[c]),
      .pulse (cpu_reset[c])
    );
  end

endmodule
